mem_stage_hs: RTL and testbench

- Parametrised successor to the pipeline CPU memory stage.
- Passes ALU results, target register and opcode through one register stage to writeback.
- Adds a request/acknowledge data-memory handshake with variable latency, load-data return, pipeline stall generation and an access timeout.
- Sits between execute and writeback; a single stall_out freezes all upstream stages.

---
 rtl/mem_stage_hs_if.sv | 29 ++
 rtl/mem_stage_hs.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_hs.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and the memory (slave).
interface mem_stage_hs_if #(
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage with variable-latency req/ack data-memory handshake, stall and timeout.
// Optional saturating stall/access counters are enabled by defining MEM_STAGE_STATS_EN.
module mem_stage_hs #(
  parameter int unsigned     DATA_W  = 16,
  parameter int unsigned     TGT_W   = 3,
  parameter int unsigned     OP_W    = 3,
  parameter logic [OP_W-1:0] OP_SW   = 3'b100,
  parameter logic [OP_W-1:0] OP_LW   = 3'b101,
  parameter int unsigned     TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bubble_in,
  input  logic [OP_W-1:0]    opcode_in,
  input  logic [TGT_W-1:0]   tgt_in,
  input  logic [DATA_W-1:0]  result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic               halt_in,
  mem_stage_hs_if.master     mem,
  output logic               stall_out,
  output logic [TGT_W-1:0]   tgt_out,
  output logic [OP_W-1:0]    opcode_out,
  output logic [DATA_W-1:0]  result_out,
  output logic               bubble_out,
  output logic               halt_out,
`ifdef MEM_STAGE_STATS_EN
  output logic [15:0]        stat_stalls,
  output logic [15:0]        stat_accesses,
`endif
  output logic               err_out
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [TGT_W-1:0]  tgt_q, tgt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              bubble_q, bubble_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic is_mem;
  logic timeout_now;
  logic stall;
  logic complete;

  // Halted pipeline issues no further memory traffic.
  assign is_mem = ((opcode_in == OP_SW) || (opcode_in == OP_LW)) && !bubble_in && !halt_q;

  assign mem.mem_req   = is_mem;
  assign mem.mem_we    = is_mem && (opcode_in == OP_SW);
  assign mem.mem_addr  = result_in;
  assign mem.mem_wdata = store_data_in;

  assign timeout_now = (state_q == StWait) && (cnt_q == TimeoutCnt) && !mem.mem_ack;
  assign stall       = is_mem && !mem.mem_ack && !timeout_now;
  assign complete    = is_mem && !stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem && !mem.mem_ack) begin
          state_d = StWait;
          cnt_d   = 8'd1;
        end
      end
      StWait: begin
        if (!is_mem || mem.mem_ack || timeout_now) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    tgt_d    = tgt_q;
    op_d     = op_q;
    result_d = result_q;
    bubble_d = bubble_q;
    halt_d   = halt_q;
    err_d    = err_q;
    if (stall) begin
      bubble_d = 1'b1;
    end else begin
      tgt_d  = tgt_in;
      op_d   = opcode_in;
      halt_d = halt_in;
      if (complete) begin
        result_d = (opcode_in == OP_LW) ? mem.mem_rdata : result_in;
        // A timed-out access retires as a bubble and latches the error.
        bubble_d = timeout_now;
        err_d    = err_q | timeout_now;
      end else begin
        result_d = result_in;
        bubble_d = halt_q | bubble_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      tgt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      bubble_q <= 1'b1;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      op_q     <= op_d;
      result_q <= result_d;
      bubble_q <= bubble_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
    end
  end

  assign stall_out  = stall;
  assign tgt_out    = tgt_q;
  assign opcode_out = op_q;
  assign result_out = result_q;
  assign bubble_out = bubble_q;
  assign halt_out   = halt_q;
  assign err_out    = err_q;

`ifdef MEM_STAGE_STATS_EN
  logic [15:0] stalls_q, accesses_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stalls_q   <= '0;
      accesses_q <= '0;
    end else begin
      if (stall && (stalls_q != 16'hFFFF)) begin
        stalls_q <= stalls_q + 16'd1;
      end
      if (complete && (accesses_q != 16'hFFFF)) begin
        accesses_q <= accesses_q + 16'd1;
      end
    end
  end

  assign stat_stalls   = stalls_q;
  assign stat_accesses = accesses_q;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: expected retirements queued at issue, checked at output.
module tb_mem_stage_hs;
  localparam logic [2:0] OpSw = 3'b100;
  localparam logic [2:0] OpLw = 3'b101;
  localparam logic [2:0] OpAlu = 3'b000;

  logic        clk = 1'b0;
  logic        rst;
  logic        bubble_in;
  logic [2:0]  opcode_in;
  logic [2:0]  tgt_in;
  logic [15:0] result_in;
  logic [15:0] store_data_in;
  logic        halt_in;
  logic        stall_out;
  logic [2:0]  tgt_out;
  logic [2:0]  opcode_out;
  logic [15:0] result_out;
  logic        bubble_out;
  logic        halt_out;
  logic        err_out;
`ifdef MEM_STAGE_STATS_EN
  logic [15:0] stat_stalls;
  logic [15:0] stat_accesses;
`endif

  mem_stage_hs_if #(.DATA_W(16)) mem_bus ();

  mem_stage_hs #(
    .DATA_W (16),
    .TGT_W  (3),
    .OP_W   (3),
    .OP_SW  (OpSw),
    .OP_LW  (OpLw),
    .TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bubble_in    (bubble_in),
    .opcode_in    (opcode_in),
    .tgt_in       (tgt_in),
    .result_in    (result_in),
    .store_data_in(store_data_in),
    .halt_in      (halt_in),
    .mem          (mem_bus),
    .stall_out    (stall_out),
    .tgt_out      (tgt_out),
    .opcode_out   (opcode_out),
    .result_out   (result_out),
    .bubble_out   (bubble_out),
    .halt_out     (halt_out),
`ifdef MEM_STAGE_STATS_EN
    .stat_stalls  (stat_stalls),
    .stat_accesses(stat_accesses),
`endif
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  tgt;
    logic [2:0]  op;
    logic [15:0] res;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  // Every non-bubble retirement must match the oldest queued expectation.
  always @(posedge clk) begin
    #2;
    if (bubble_out === 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got tgt=%0d op=%0d res=%h, required no retirement",
                 tgt_out, opcode_out, result_out);
      end else begin
        e = exp_q.pop_front();
        if (tgt_out !== e.tgt || opcode_out !== e.op || result_out !== e.res) begin
          bad++;
          $display("FAIL sb_out got tgt=%0d op=%0d res=%h, required tgt=%0d op=%0d res=%h",
                   tgt_out, opcode_out, result_out, e.tgt, e.op, e.res);
        end
      end
    end
  end

  task automatic set_idle();
    bubble_in         = 1'b1;
    opcode_in         = OpAlu;
    tgt_in            = '0;
    result_in         = '0;
    store_data_in     = '0;
    halt_in           = 1'b0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] tgt, input logic [15:0] res,
                       input logic [15:0] sd);
    bubble_in     = 1'b0;
    opcode_in     = op;
    tgt_in        = tgt;
    result_in     = res;
    store_data_in = sd;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (bubble_out !== 1'b1 || halt_out !== 1'b0 || err_out !== 1'b0 || tgt_out !== 3'd0 ||
        opcode_out !== 3'd0 || result_out !== 16'h0) begin
      bad++;
      $display("FAIL reset_state got b=%b h=%b e=%b t=%0d o=%0d r=%h, required b=1 h=0 e=0 t=o=r=0",
               bubble_out, halt_out, err_out, tgt_out, opcode_out, result_out);
    end
    total++;
    if (stall_out !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got stall=%b req=%b, required 0 0", stall_out, mem_bus.mem_req);
    end
  endtask

  task automatic test_alu();
    @(posedge clk);
    #1 drive(OpAlu, 3'd3, 16'h1234, 16'h0);
    exp_q.push_back('{tgt: 3'd3, op: OpAlu, res: 16'h1234});
    #1;
    total++;
    if (mem_bus.mem_req !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL alu_noreq got req=%b stall=%b, required 0 0", mem_bus.mem_req, stall_out);
    end
    @(posedge clk);
    #1 set_idle();
    total++;
    if (bubble_out !== 1'b0) begin
      bad++;
      $display("FAIL alu_bubble got %b, required 0", bubble_out);
    end
    @(posedge clk);
    #1;
    total++;
    if (bubble_out !== 1'b1) begin
      bad++;
      $display("FAIL alu_bubble_pass got %b, required 1", bubble_out);
    end
  endtask

  task automatic test_zero_wait_load();
    @(posedge clk);
    #1 drive(OpLw, 3'd1, 16'h0040, 16'h0);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 16'hBEEF;
    exp_q.push_back('{tgt: 3'd1, op: OpLw, res: 16'hBEEF});
    #1;
    total++;
    if (stall_out !== 1'b0 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_req !== 1'b1 ||
        mem_bus.mem_addr !== 16'h0040) begin
      bad++;
      $display("FAIL lw0_bus got stall=%b we=%b req=%b addr=%h, required 0 0 1 0040",
               stall_out, mem_bus.mem_we, mem_bus.mem_req, mem_bus.mem_addr);
    end
    @(posedge clk);
    #1 set_idle();
  endtask

  task automatic test_wait_store();
    @(posedge clk);
    #1 drive(OpSw, 3'd5, 16'h0010, 16'h00AA);
    exp_q.push_back('{tgt: 3'd5, op: OpSw, res: 16'h0010});
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall_out !== 1'b1 || mem_bus.mem_we !== 1'b1 || mem_bus.mem_wdata !== 16'h00AA) begin
        bad++;
        $display("FAIL sw3_wait cyc=%0d got stall=%b we=%b wdata=%h, required 1 1 00aa",
                 i, stall_out, mem_bus.mem_we, mem_bus.mem_wdata);
      end
      @(posedge clk);
      #1;
      total++;
      if (bubble_out !== 1'b1) begin
        bad++;
        $display("FAIL sw3_bubble cyc=%0d got %b, required 1", i, bubble_out);
      end
    end
    mem_bus.mem_ack = 1'b1;
    #1;
    total++;
    if (stall_out !== 1'b0 || mem_bus.mem_we !== 1'b1) begin
      bad++;
      $display("FAIL sw3_ack got stall=%b we=%b, required 0 1", stall_out, mem_bus.mem_we);
    end
    @(posedge clk);
    #1 set_idle();
  endtask

  task automatic test_timeout();
    int n = 0;
    @(posedge clk);
    #1 drive(OpLw, 3'd2, 16'h0077, 16'h0);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall_out !== 1'b1) break;
      n++;
      @(posedge clk);
      #1;
    end
    total++;
    if (n != 15 || mem_bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL timeout_len got stalls=%0d req=%b, required 15 1", n, mem_bus.mem_req);
    end
    @(posedge clk);
    #1;
    total++;
    if (err_out !== 1'b1 || bubble_out !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err got err=%b bubble=%b, required 1 1", err_out, bubble_out);
    end
    set_idle();
    #1;
    total++;
    if (mem_bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_req got %b, required 0", mem_bus.mem_req);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (err_out !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky got %b, required 1", err_out);
    end
  endtask

  task automatic test_halt();
    @(posedge clk);
    #1 set_idle();
    halt_in = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (halt_out !== 1'b1) begin
      bad++;
      $display("FAIL halt_out got %b, required 1", halt_out);
    end
    drive(OpSw, 3'd4, 16'h0020, 16'h0055);
    #1;
    total++;
    if (mem_bus.mem_req !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL halt_noreq got req=%b stall=%b, required 0 0", mem_bus.mem_req, stall_out);
    end
    @(posedge clk);
    #1;
    total++;
    if (bubble_out !== 1'b1) begin
      bad++;
      $display("FAIL halt_bubble got %b, required 1", bubble_out);
    end
    set_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk);
    #1 drive(OpLw, 3'd6, 16'h0090, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_idle();
    #1;
    total++;
    if (bubble_out !== 1'b1 || err_out !== 1'b0 || stall_out !== 1'b0 ||
        mem_bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait got b=%b e=%b stall=%b req=%b, required 1 0 0 0",
               bubble_out, err_out, stall_out, mem_bus.mem_req);
    end
    // A fresh access must see an idle FSM: full timeout window again.
    test_timeout();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[4];
    logic [15:0] res[4];
    ops[0] = OpAlu; res[0] = 16'h1111;
    ops[1] = OpLw;  res[1] = 16'hCAFE;
    ops[2] = OpAlu; res[2] = 16'h3333;
    ops[3] = OpSw;  res[3] = 16'h0044;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 drive(ops[i], 3'(i + 1), res[i], 16'h5A5A);
      // Ack is asserted on every slot; it must be ignored for non-memory ops.
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = 16'hCAFE;
      exp_q.push_back('{tgt: 3'(i + 1), op: ops[i], res: res[i]});
      #1;
      total++;
      if (stall_out !== 1'b0) begin
        bad++;
        $display("FAIL b2b_stall slot=%0d got %b, required 0", i, stall_out);
      end
      @(posedge clk);
    end
    #1 set_idle();
    @(posedge clk);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_alu();
    test_zero_wait_load();
    test_wait_store();
    test_back_to_back();
    test_timeout();
    test_reset();
    test_halt();
    test_reset();
    test_reset_mid_wait();
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
